// File: rtl/ddr_cmd_decoder.sv
// rtl/ddr_cmd_decoder.sv - DDR4 command/address pin decoder with per-bank state and timing checks
// Samples the CA pins every clock, registers the decoded command, and flags protocol/timing violations.
module ddr_cmd_decoder #(
  parameter int BG_WIDTH  = 2,
  parameter int BA_WIDTH  = 2,
  parameter int CNT_WIDTH = 8,
  parameter int T_RCD     = 16,
  parameter int T_RP      = 16,
  parameter int T_RAS     = 39
) (
  input  logic                                  clock_t,
  input  logic                                  reset_n,
  input  logic                                  cs_n,
  input  logic                                  act_n,
  input  logic                                  ras_n_a16,
  input  logic                                  cas_n_a15,
  input  logic                                  we_n_a14,
  input  logic                                  addr17,
  input  logic                                  addr13,
  input  logic                                  bc_n_a12,
  input  logic                                  addr11,
  input  logic                                  ap_a10,
  input  logic [9:0]                            addr9_0,
  input  logic [BG_WIDTH-1:0]                   bg_addr,
  input  logic [BA_WIDTH-1:0]                   ba_addr,
  output logic                                  cmd_valid,
  output logic [3:0]                            cmd_code,
  output logic [BG_WIDTH-1:0]                   cmd_bg,
  output logic [BA_WIDTH-1:0]                   cmd_ba,
  output logic [17:0]                           cmd_row,
  output logic [9:0]                            cmd_col,
  output logic                                  cmd_bc_n,
  output logic [2**(BG_WIDTH+BA_WIDTH)-1:0]     bank_open,
  output logic                                  err_valid,
  output logic [2:0]                            err_code
);

  localparam int NUM_BANKS = 2**(BG_WIDTH+BA_WIDTH);
  localparam int IDX_W     = BG_WIDTH + BA_WIDTH;

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_ACT   = 4'd1;
  localparam logic [3:0] CMD_PRE   = 4'd2;
  localparam logic [3:0] CMD_PREA  = 4'd3;
  localparam logic [3:0] CMD_CAS_R = 4'd4;
  localparam logic [3:0] CMD_CAS_W = 4'd5;
  localparam logic [3:0] CMD_MRS   = 4'd6;
  localparam logic [3:0] CMD_REF   = 4'd7;
  localparam logic [3:0] CMD_ZQCL  = 4'd8;
  localparam logic [3:0] CMD_RFU   = 4'd15;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_X     = 3'd1;
  localparam logic [2:0] ERR_ACT   = 3'd2;
  localparam logic [2:0] ERR_CAS   = 3'd3;
  localparam logic [2:0] ERR_RCD   = 3'd4;
  localparam logic [2:0] ERR_RAS   = 3'd5;
  localparam logic [2:0] ERR_RP    = 3'd6;
  localparam logic [2:0] ERR_REF   = 3'd7;

  localparam logic [CNT_WIDTH-1:0] RCD_C = CNT_WIDTH'(T_RCD);
  localparam logic [CNT_WIDTH-1:0] RP_C  = CNT_WIDTH'(T_RP);
  localparam logic [CNT_WIDTH-1:0] RAS_C = CNT_WIDTH'(T_RAS);

  logic                 cmd_valid_q, cmd_valid_d;
  logic [3:0]           cmd_code_q, cmd_code_d;
  logic [BG_WIDTH-1:0]  cmd_bg_q;
  logic [BA_WIDTH-1:0]  cmd_ba_q;
  logic [17:0]          cmd_row_q;
  logic [9:0]           cmd_col_q;
  logic                 cmd_bc_n_q;
  logic                 err_valid_q, err_valid_d;
  logic [2:0]           err_code_q, err_code_d;
  logic [NUM_BANKS-1:0] bank_open_q, bank_open_d;
  logic [CNT_WIDTH-1:0] act_cnt_q [NUM_BANKS];
  logic [CNT_WIDTH-1:0] act_cnt_d [NUM_BANKS];
  logic [CNT_WIDTH-1:0] pre_cnt_q [NUM_BANKS];
  logic [CNT_WIDTH-1:0] pre_cnt_d [NUM_BANKS];
  // Cycles elapsed at this edge: the stored count plus the cycle now ending.
  logic [CNT_WIDTH-1:0] act_el [NUM_BANKS];
  logic [CNT_WIDTH-1:0] pre_el [NUM_BANKS];

  logic [IDX_W-1:0] idx;
  logic [17:0]      row_w;
  logic             ctrl_x;
  logic             ras_viol;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign idx    = {bg_addr, ba_addr};
  assign row_w  = {addr17, ras_n_a16, cas_n_a15, we_n_a14, addr13, bc_n_a12, addr11, ap_a10, addr9_0};
  assign ctrl_x = $isunknown(cs_n) || (!cs_n && $isunknown({act_n, ras_n_a16, cas_n_a15, we_n_a14}));

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      act_el[i] = sat_inc(act_cnt_q[i]);
      pre_el[i] = sat_inc(pre_cnt_q[i]);
    end
  end

  always_comb begin
    cmd_valid_d = 1'b0;
    cmd_code_d  = CMD_NOP;
    err_valid_d = 1'b0;
    err_code_d  = ERR_NONE;
    bank_open_d = bank_open_q;
    ras_viol    = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      act_cnt_d[i] = act_el[i];
      pre_cnt_d[i] = pre_el[i];
    end
    if (ctrl_x) begin
      cmd_valid_d = 1'b1;
      cmd_code_d  = CMD_RFU;
      err_valid_d = 1'b1;
      err_code_d  = ERR_X;
    end else if (!cs_n) begin
      cmd_valid_d = 1'b1;
      if (!act_n) begin
        cmd_code_d = CMD_ACT;
        if (bank_open_q[idx]) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_ACT;
        end else if (pre_el[idx] < RP_C) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_RP;
        end
        bank_open_d[idx] = 1'b1;
        act_cnt_d[idx]   = '0;
      end else begin
        case ({ras_n_a16, cas_n_a15, we_n_a14})
          3'b000: cmd_code_d = CMD_MRS;
          3'b001, 3'b110: begin
            cmd_code_d = we_n_a14 ? CMD_REF : CMD_ZQCL;
            if (|bank_open_q) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_REF;
            end
          end
          3'b010: begin
            if (ap_a10) begin
              cmd_code_d = CMD_PREA;
              for (int i = 0; i < NUM_BANKS; i++) begin
                if (bank_open_q[i] && act_el[i] < RAS_C) ras_viol = 1'b1;
                pre_cnt_d[i] = '0;
              end
              bank_open_d = '0;
            end else begin
              cmd_code_d = CMD_PRE;
              ras_viol   = bank_open_q[idx] && (act_el[idx] < RAS_C);
              bank_open_d[idx] = 1'b0;
              pre_cnt_d[idx]   = '0;
            end
            if (ras_viol) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_RAS;
            end
          end
          3'b011: cmd_code_d = CMD_RFU;
          3'b100, 3'b101: begin
            cmd_code_d = we_n_a14 ? CMD_CAS_R : CMD_CAS_W;
            if (!bank_open_q[idx]) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_CAS;
            end else if (act_el[idx] < RCD_C) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_RCD;
            end
          end
          default: cmd_valid_d = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_NOP;
      cmd_bg_q    <= '0;
      cmd_ba_q    <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      cmd_bc_n_q  <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      bank_open_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        act_cnt_q[i] <= '1;
        pre_cnt_q[i] <= '1;
      end
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      bank_open_q <= bank_open_d;
      if (cmd_valid_d) begin
        cmd_bg_q   <= bg_addr;
        cmd_ba_q   <= ba_addr;
        cmd_row_q  <= row_w;
        cmd_col_q  <= addr9_0;
        cmd_bc_n_q <= bc_n_a12;
      end
      for (int i = 0; i < NUM_BANKS; i++) begin
        act_cnt_q[i] <= act_cnt_d[i];
        pre_cnt_q[i] <= pre_cnt_d[i];
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_bg    = cmd_bg_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign cmd_bc_n  = cmd_bc_n_q;
  assign bank_open = bank_open_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// tb/tb_ddr_cmd_decoder.sv - directed-vector bench for ddr_cmd_decoder
// Each command occupies one clock; outputs are checked 1 time unit after the sampling edge.
module tb_ddr_cmd_decoder;

  logic        clock_t = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs_n = 1'b1, act_n = 1'b1;
  logic        ras_n_a16 = 1'b1, cas_n_a15 = 1'b1, we_n_a14 = 1'b1;
  logic        addr17 = 1'b0, addr13 = 1'b0, bc_n_a12 = 1'b0, addr11 = 1'b0, ap_a10 = 1'b0;
  logic [9:0]  addr9_0 = '0;
  logic [1:0]  bg_addr = '0, ba_addr = '0;
  logic        cmd_valid, cmd_bc_n, err_valid;
  logic [3:0]  cmd_code;
  logic [1:0]  cmd_bg, cmd_ba;
  logic [17:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [15:0] bank_open;
  logic [2:0]  err_code;
  logic        probe;

  int total = 0;
  int bad   = 0;

  ddr_cmd_decoder dut (
    .clock_t(clock_t), .reset_n(reset_n), .cs_n(cs_n), .act_n(act_n),
    .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14),
    .addr17(addr17), .addr13(addr13), .bc_n_a12(bc_n_a12), .addr11(addr11),
    .ap_a10(ap_a10), .addr9_0(addr9_0), .bg_addr(bg_addr), .ba_addr(ba_addr),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_bc_n(cmd_bc_n),
    .bank_open(bank_open), .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clock_t = ~clock_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic cs, input logic act, input logic [17:0] a,
                       input logic [1:0] bg, input logic [1:0] ba);
    cs_n = cs; act_n = act;
    addr17 = a[17]; ras_n_a16 = a[16]; cas_n_a15 = a[15]; we_n_a14 = a[14];
    addr13 = a[13]; bc_n_a12 = a[12]; addr11 = a[11]; ap_a10 = a[10]; addr9_0 = a[9:0];
    bg_addr = bg; ba_addr = ba;
    @(posedge clock_t);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 18'h3FFFF, 2'd0, 2'd0);
  endtask

  task automatic act(input logic [1:0] bg, input logic [1:0] ba, input logic [17:0] row);
    drive(1'b0, 1'b0, row, bg, ba);
  endtask

  // rcw = {ras_n, cas_n, we_n}
  task automatic cmd(input logic [2:0] rcw, input logic [1:0] bg, input logic [1:0] ba,
                     input logic a10, input logic bc, input logic [9:0] col);
    drive(1'b0, 1'b1, {1'b0, rcw, 1'b0, bc, 1'b0, a10, col}, bg, ba);
  endtask

  initial begin
    repeat (3) @(posedge clock_t);
    #1;
    chk("rst_code", {28'd0, cmd_code}, 32'd0);
    chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_open", {16'd0, bank_open}, 32'd0);
    reset_n = 1'b1;
    idle(20);
    chk("des_valid", {31'd0, cmd_valid}, 32'd0);
    chk("des_err", {31'd0, err_valid}, 32'd0);
    chk("des_open", {16'd0, bank_open}, 32'd0);

    // Clean ACT / CAS_R at tRCD / PRE at tRAS on bank 6
    act(2'd1, 2'd2, 18'h01234);
    chk("act_valid", {31'd0, cmd_valid}, 32'd1);
    chk("act_code", {28'd0, cmd_code}, 32'd1);
    chk("act_bg", {30'd0, cmd_bg}, 32'd1);
    chk("act_ba", {30'd0, cmd_ba}, 32'd2);
    chk("act_row", {14'd0, cmd_row}, 32'h1234);
    chk("act_err", {31'd0, err_valid}, 32'd0);
    chk("act_open", {16'd0, bank_open}, 32'h0040);
    idle(15);
    cmd(3'b101, 2'd1, 2'd2, 1'b0, 1'b1, 10'h05A);
    chk("casr_code", {28'd0, cmd_code}, 32'd4);
    chk("casr_col", {22'd0, cmd_col}, 32'h05A);
    chk("casr_bc", {31'd0, cmd_bc_n}, 32'd1);
    chk("casr_err", {31'd0, err_valid}, 32'd0);
    idle(22);
    cmd(3'b010, 2'd1, 2'd2, 1'b0, 1'b0, 10'h000);
    chk("pre_code", {28'd0, cmd_code}, 32'd2);
    chk("pre_err", {31'd0, err_valid}, 32'd0);
    chk("pre_open", {16'd0, bank_open}, 32'h0000);

    // One cycle short of each timing limit on bank 0
    act(2'd0, 2'd0, 18'h00000);
    chk("act0_open", {16'd0, bank_open}, 32'h0001);
    idle(14);
    cmd(3'b100, 2'd0, 2'd0, 1'b0, 1'b1, 10'h001);
    chk("casw_code", {28'd0, cmd_code}, 32'd5);
    chk("rcd_err", {29'd0, err_code}, 32'd4);
    chk("rcd_errv", {31'd0, err_valid}, 32'd1);
    idle(22);
    cmd(3'b010, 2'd0, 2'd0, 1'b0, 1'b0, 10'h000);
    chk("ras_err", {29'd0, err_code}, 32'd5);
    chk("ras_open", {16'd0, bank_open}, 32'h0000);
    idle(14);
    act(2'd0, 2'd0, 18'h00000);
    chk("rp_err", {29'd0, err_code}, 32'd6);
    chk("rp_open", {16'd0, bank_open}, 32'h0001);

    // Protocol errors on bank 3
    cmd(3'b101, 2'd0, 2'd3, 1'b0, 1'b1, 10'h000);
    chk("casidle_err", {29'd0, err_code}, 32'd3);
    chk("casidle_open", {16'd0, bank_open}, 32'h0001);
    act(2'd0, 2'd3, 18'h00010);
    chk("act3_err", {31'd0, err_valid}, 32'd0);
    act(2'd0, 2'd3, 18'h00010);
    chk("act3_again", {29'd0, err_code}, 32'd2);
    chk("act3_open", {16'd0, bank_open}, 32'h0009);

    // REF with banks 0/5 open, PREA exactly at tRAS, ACT exactly at tRP
    idle(40);
    cmd(3'b010, 2'd0, 2'd3, 1'b0, 1'b0, 10'h000);
    chk("pre3_err", {31'd0, err_valid}, 32'd0);
    act(2'd1, 2'd1, 18'h00055);
    chk("act5_open", {16'd0, bank_open}, 32'h0021);
    cmd(3'b001, 2'd0, 2'd0, 1'b0, 1'b0, 10'h000);
    chk("ref_code", {28'd0, cmd_code}, 32'd7);
    chk("ref_err", {29'd0, err_code}, 32'd7);
    idle(37);
    cmd(3'b010, 2'd0, 2'd0, 1'b1, 1'b0, 10'h000);
    chk("prea_code", {28'd0, cmd_code}, 32'd3);
    chk("prea_err", {31'd0, err_valid}, 32'd0);
    chk("prea_open", {16'd0, bank_open}, 32'h0000);
    cmd(3'b001, 2'd0, 2'd0, 1'b0, 1'b0, 10'h000);
    chk("ref2_err", {31'd0, err_valid}, 32'd0);
    idle(14);
    act(2'd1, 2'd2, 18'h00777);
    chk("rpedge_err", {31'd0, err_valid}, 32'd0);
    chk("rpedge_open", {16'd0, bank_open}, 32'h0040);

    // Remaining decodes
    cmd(3'b000, 2'd2, 2'd1, 1'b1, 1'b0, 10'h3C5);
    chk("mrs_code", {28'd0, cmd_code}, 32'd6);
    chk("mrs_row", {14'd0, cmd_row}, 32'h007C5);
    cmd(3'b011, 2'd0, 2'd0, 1'b0, 1'b0, 10'h000);
    chk("rfu_code", {28'd0, cmd_code}, 32'd15);
    chk("rfu_err", {31'd0, err_valid}, 32'd0);
    cmd(3'b111, 2'd0, 2'd0, 1'b0, 1'b0, 10'h000);
    chk("nop_valid", {31'd0, cmd_valid}, 32'd0);
    cmd(3'b110, 2'd0, 2'd0, 1'b0, 1'b0, 10'h000);
    chk("zq_code", {28'd0, cmd_code}, 32'd8);
    chk("zq_err", {29'd0, err_code}, 32'd7);

    // Unknown control pin; a 2-state simulator resolves X to a legal non-bank command
    probe = 1'bx;
    cs_n = 1'b0; act_n = 1'b1; ras_n_a16 = 1'bx; cas_n_a15 = 1'b1; we_n_a14 = 1'b1;
    @(posedge clock_t);
    #1;
    if ($isunknown(probe)) begin
      chk("x_code", {28'd0, cmd_code}, 32'd15);
      chk("x_err", {29'd0, err_code}, 32'd1);
      chk("x_valid", {31'd0, cmd_valid}, 32'd1);
    end
    chk("x_open", {16'd0, bank_open}, 32'h0040);
    idle(1);

    // Asynchronous reset with bank 6 open
    reset_n = 1'b0;
    #2;
    chk("arst_open", {16'd0, bank_open}, 32'h0000);
    chk("arst_valid", {31'd0, cmd_valid}, 32'd0);
    @(posedge clock_t);
    #1;
    reset_n = 1'b1;
    act(2'd1, 2'd2, 18'h00001);
    chk("postrst_err", {31'd0, err_valid}, 32'd0);
    chk("postrst_open", {16'd0, bank_open}, 32'h0040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
